// File: rtl/cpu_controller.sv
// Instruction register, decoder and sequencing FSM for the 16-bit CPU.
// Drives every datapath control one state per cycle; control outputs are registered Moore outputs.
module cpu_controller #(
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG
  } state_t;

  typedef enum logic [2:0] {
    I_MOV_IMM, I_MOV_REG, I_MVN, I_ADD, I_CMP, I_AND, I_BAD
  } instr_t;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic       write;
  } ctrl_t;

  function automatic instr_t classify(input logic [15:0] word);
    case (word[15:11])
      5'b110_10: return I_MOV_IMM;
      5'b110_00: return I_MOV_REG;
      5'b101_11: return I_MVN;
      5'b101_00: return I_ADD;
      5'b101_01: return I_CMP;
      5'b101_10: return I_AND;
      default:   return I_BAD;
    endcase
  endfunction

  function automatic state_t next_of(input state_t st, input instr_t ins, input logic start);
    case (st)
      S_WAIT:      return start ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case (ins)
          I_MOV_IMM:             return S_WRITE_IMM;
          I_MOV_REG, I_MVN:      return S_GET_B;
          I_ADD, I_CMP, I_AND:   return S_GET_A;
          default:               return S_WAIT;
        endcase
      end
      S_GET_A:     return S_GET_B;
      S_GET_B:     return S_EXEC;
      S_EXEC:      return (ins == I_CMP) ? S_WAIT : S_WRITE_REG;
      default:     return S_WAIT;
    endcase
  endfunction

  // Control word presented while sitting in state st with instruction word loaded.
  function automatic ctrl_t ctrl_of(input state_t st, input logic [15:0] word);
    ctrl_t  c;
    instr_t ins;
    c   = '0;
    ins = classify(word);
    case (st)
      S_WAIT:      c.w = 1'b1;
      S_WRITE_IMM: begin
        c.writenum = word[10:8];
        c.vsel     = 2'b10;
        c.write    = 1'b1;
      end
      S_GET_A: begin
        c.readnum = word[10:8];
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        c.readnum = word[2:0];
        c.loadb   = 1'b1;
      end
      S_EXEC: begin
        c.asel = (ins == I_MOV_REG) || (ins == I_MVN);
        if (ins == I_CMP) c.loads = 1'b1;
        else              c.loadc = 1'b1;
      end
      S_WRITE_REG: begin
        c.writenum = word[7:5];
        c.vsel     = 2'b00;
        c.write    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t      state, state_next;
  logic [15:0] ir, ir_next;
  ctrl_t       ctrl;
  instr_t      ins;

  assign ins = classify(ir);

  // NOTE: every variable assigned in always_comb gets a value on every path (defaults first), otherwise a latch is inferred.
  always_comb begin
    ir_next    = ir;
    state_next = next_of(state, ins, s);
    if (state == S_WAIT && load) ir_next = in;
  end

  // NOTE: IR is reset explicitly because its value after reset is architecturally visible through the decode outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= IR_RESET;
      ctrl  <= ctrl_of(S_WAIT, IR_RESET);
    end else begin
      state <= state_next;
      ir    <= ir_next;
      ctrl  <= ctrl_of(state_next, ir_next);
    end
  end

  assign w        = ctrl.w;
  assign readnum  = ctrl.readnum;
  assign writenum = ctrl.writenum;
  assign vsel     = ctrl.vsel;
  assign loada    = ctrl.loada;
  assign loadb    = ctrl.loadb;
  assign asel     = ctrl.asel;
  assign bsel     = ctrl.bsel;
  assign loadc    = ctrl.loadc;
  assign loads    = ctrl.loads;
  assign write    = ctrl.write;

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign shift  = (ins == I_MOV_IMM) ? 2'b00 : ir[4:3];
  assign ALUop  = (ins == I_MOV_REG) ? 2'b00 : ir[12:11];

endmodule
